// File: rtl/pipe_stage_ctrl.sv
// Consuming-side handshake controller for a single-entry inter-stage pipe buffer.
// Pops an item, holds it for a programmable number of busy cycles, then pushes it downstream.
module pipe_stage_ctrl #(
    parameter type         T       = logic,
    parameter int unsigned MAX_LAT = 34,
    parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             up_valid_in,
    input  T                 up_data_in,
    output logic             up_read_out,
    input  logic [LAT_W-1:0] lat_in,
    input  logic             dn_full_in,
    output logic             dn_write_out,
    output T                 dn_data_out,
    input  logic             flush_in,
    output logic             busy_out,
    output logic [31:0]      stall_cnt_out
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    T                 data_q, data_d;
    logic [31:0]      stall_q, stall_d;

    logic             accept;
    logic             write;
    logic [LAT_W-1:0] lat_sat;

    assign lat_sat = (lat_in > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat_in;

    // Write never depends on up_valid_in; accept in HOLD rides on the write.
    assign write = (state_q == StHold) && !dn_full_in && !flush_in;

    // Gating with reset_in keeps up_read_out low while reset is held, even in IDLE.
    assign accept = reset_in && up_valid_in && !flush_in &&
                    ((state_q == StIdle) || write);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        stall_d = stall_q;

        if ((state_q == StHold) && dn_full_in && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end

        if (flush_in) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (accept) begin
            data_d = up_data_in;
            if (lat_sat == '0) begin
                state_d = StHold;
                cnt_d   = '0;
            end else begin
                state_d = StBusy;
                cnt_d   = lat_sat;
            end
        end else begin
            unique case (state_q)
                StBusy: begin
                    cnt_d = cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (write) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

    assign up_read_out   = accept;
    assign dn_write_out  = write;
    assign dn_data_out   = data_q;
    assign busy_out      = (state_q != StIdle);
    assign stall_cnt_out = stall_q;

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Stage-side handshake controller for the consuming end of a single-entry inter-stage pipe buffer. It pops items from the upstream pipe, holds each item for a programmable number of busy cycles (multi-cycle ops such as divide), then pushes the item into the downstream pipe, stalling while that pipe is full. Every execution-pipeline stage that reads from a pipe and writes to the next one instantiates it.

## Interface
Parameters:
- T, logic, payload type carried between stages
- MAX_LAT, 34, maximum extra busy cycles per item; LAT_W = $clog2(MAX_LAT+1)

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  reset, asynchronous assert, active-low, synchronous deassert assumed from system
- up_valid_in  input  1  upstream pipe holds an item
- up_data_in  input  T  upstream pipe item
- up_read_out  output  1  pop upstream item this cycle (drives upstream pipe read_in)
- lat_in  input  LAT_W  extra busy cycles for the item on up_data_in, sampled on accept
- dn_full_in  input  1  downstream pipe cannot accept a write this cycle
- dn_write_out  output  1  push dn_data_out this cycle (drives downstream pipe write_in)
- dn_data_out  output  T  held item
- flush_in  input  1  discard held item, block accept
- busy_out  output  1  an item is held (state != IDLE)
- stall_cnt_out  output  32  cycles spent in HOLD with dn_full_in high, saturating

## Operation
- States: IDLE (empty), BUSY (counting down), HOLD (item ready, waiting downstream).
- accept = up_valid_in && !flush_in && (state==IDLE || (state==HOLD && dn_write_out)).
- up_read_out = accept (combinational).
- dn_write_out = (state==HOLD) && !dn_full_in && !flush_in (combinational).
- On accept: dn_data_out <= up_data_in; lat = min(lat_in, MAX_LAT); lat==0 -> HOLD, else BUSY with cnt <= lat.
- BUSY: cnt decrements each cycle; cnt==1 -> HOLD; cnt==0 never occurs in BUSY.
- HOLD: dn_write_out && !accept -> IDLE; dn_write_out && accept -> reload per accept rule (back-to-back, no bubble); dn_full_in -> stay, stall_cnt_out += 1 (saturates at 32'hFFFF_FFFF).
- dn_data_out stable from accept until the cycle after the write; not cleared on write or flush.
- flush_in (any state): next state IDLE, cnt <= 0; no accept, no write that cycle; upstream item remains in upstream pipe.
- Priority: reset > flush_in > write/accept > count.
- dn_full_in is not used to gate up_read_out except via dn_write_out; no combinational path from up_valid_in to dn_write_out.

## Timing
- Reset values: state IDLE, cnt 0, dn_data_out '0, stall_cnt_out 0, busy_out 0, up_read_out 0 while up_valid_in 0, dn_write_out 0.
- Latency, accept edge to dn_write_out high (downstream not full): 1 + lat cycles.
- Throughput with lat=0 and downstream free: one item per cycle.
- Reset assertion mid-BUSY/HOLD: outputs return to reset values immediately (asynchronous), item lost.
- lat_in > MAX_LAT: clamped to MAX_LAT, no error.
- stall_cnt_out cleared only by reset; flush does not clear it.

## Test plan
- Reset low with up_valid_in=1 -> up_read_out=0, dn_write_out=0, busy_out=0; release, IDLE, accept on first edge.
- Stream 8 items, lat_in=0, dn_full_in=0 -> up_read_out and dn_write_out high every cycle, outputs in order, 1-cycle latency, no bubbles.
- One item lat_in=5 -> busy_out high 6 cycles before write; dn_write_out on 6th cycle after accept; up_read_out low while BUSY.
- Item in HOLD, dn_full_in=1 for 4 cycles -> dn_data_out stable, stall_cnt_out=4, write on first cycle dn_full_in=0; simultaneous next accept loads new item same edge.
- flush_in during BUSY with cnt=3 and up_valid_in=1 -> next cycle IDLE, no write, up_read_out=0 on flush cycle, item accepted cycle after.
- lat_in=63 with MAX_LAT=34 -> write 35 cycles after accept.
